// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one registered binary-to-Gray stage.
// Optional build macro GRAY_SCHED_PRIO0_EN gives requester 0 strict priority.
module gray_conv_scheduler #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_gray,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             free;
    logic             found;
    logic             ptr_upd;
    logic [IDW-1:0]   gidx;
    logic [IDW-1:0]   ci;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic [WIDTH-1:0] gword;
    logic [NREQ-1:0]  ready_vec;
    logic [WIDTH-1:0] words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign words[g] = req_data[g*WIDTH +: WIDTH];
    end

    assign free      = (state == EMPTY) || out_ready;
    assign out_valid = (state == FULL);
    assign req_ready = ready_vec;

    // Pick the first valid requester at or after rr_ptr (wrapping).
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        gword = '0;
        ci    = '0;
`ifdef GRAY_SCHED_PRIO0_EN
        if (req_valid[0]) begin
            found = 1'b1;
            gidx  = '0;
            gword = words[0];
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            ci = IDW'((int'(rr_ptr) + k) % NREQ);
`ifdef GRAY_SCHED_PRIO0_EN
            if (!found && ci != '0 && req_valid[ci]) begin
`else
            if (!found && req_valid[ci]) begin
`endif
                found = 1'b1;
                gidx  = ci;
                gword = words[ci];
            end
        end
    end

    // One-hot grant, suppressed when the slot is busy or in reset.
    always_comb begin
        ready_vec = '0;
        if (rst_n && free && found) begin
            ready_vec[gidx] = 1'b1;
        end
    end

    // Next pointer: one past the granted requester, wrapping to 0.
    always_comb begin
        ptr_nxt = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
`ifdef GRAY_SCHED_PRIO0_EN
        ptr_upd = (gidx != '0);
`else
        ptr_upd = 1'b1;
`endif
    end

    // Slot FSM: reload when free and a grant exists, else drain.
    always_comb begin
        state_nxt = state;
        if (free) begin
            state_nxt = found ? FULL : EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Result slot and round-robin pointer update on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_gray <= '0;
            out_id   <= '0;
            rr_ptr   <= '0;
        end else if (free && found) begin
            out_gray <= gword ^ (gword >> 1);
            out_id   <= gidx;
            if (ptr_upd) begin
                rr_ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Self-checking bench for gray_conv_scheduler.
// Honours GRAY_SCHED_PRIO0_EN the same way as the design build.
module tb_gray_conv_scheduler;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_gray;
    logic [IDW-1:0]        out_id;
    logic                  out_ready;

    int checks = 0;
    int errors = 0;

    int m_valid = 0;
    int m_gray  = 0;
    int m_id    = 0;
    int m_ptr   = 0;

    int rr_ids[5]    = '{0, 1, 2, 3, 0};
    int rr_grays[5]  = '{3, 7, 15, 8, 3};
    int exh_gray[16] = '{0, 1, 3, 2, 6, 7, 5, 4,
                         12, 13, 15, 14, 10, 11, 9, 8};
    int pr_ids[4]    = '{1, 2, 3, 1};
    int pr_grays[4]  = '{7, 15, 8, 7};

    gray_conv_scheduler #(
        .WIDTH(WIDTH),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_gray (out_gray),
        .out_id   (out_id),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mgrant(input logic [NREQ-1:0] v, input int ptr);
`ifdef GRAY_SCHED_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (ptr + k) % NREQ;
`ifdef GRAY_SCHED_PRIO0_EN
            if (c != 0 && v[c]) return c;
`else
            if (v[c]) return c;
`endif
        end
        return -1;
    endfunction

    // Reference model: advances on each clock edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        int g;
        int b;
        if (!rst_n) begin
            m_valid = 0;
            m_gray  = 0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (m_valid == 0 || out_ready) begin
            g = mgrant(req_valid, m_ptr);
            if (g >= 0) begin
                b       = int'(req_data[g*WIDTH +: WIDTH]);
                m_valid = 1;
                m_gray  = b ^ (b / 2);
                m_id    = g;
`ifdef GRAY_SCHED_PRIO0_EN
                if (g != 0) m_ptr = (g + 1) % NREQ;
`else
                m_ptr = (g + 1) % NREQ;
`endif
            end else begin
                m_valid = 0;
            end
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        int g;
        int er;
        if (!rst_n) begin
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_gray", int'(out_gray), 0);
            chk("rst_id", int'(out_id), 0);
            chk("rst_ready", int'(req_ready), 0);
        end else begin
            g  = mgrant(req_valid, m_ptr);
            er = ((m_valid == 0 || out_ready) && g >= 0) ? (1 << g) : 0;
            chk("ready", int'(req_ready), er);
            chk("valid", int'(out_valid), m_valid);
            if (m_valid != 0) begin
                chk("gray", int'(out_gray), m_gray);
                chk("id", int'(out_id), m_id);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #7 rst_n = 1'b1;
        req_data  = {4'd15, 4'd10, 4'd5, 4'd2};
        req_valid = 4'b1111;
`ifndef GRAY_SCHED_PRIO0_EN
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #3;
            chk("rr_id", int'(out_id), rr_ids[i]);
            chk("rr_gray", int'(out_gray), rr_grays[i]);
        end
        @(posedge clk); #3;
        chk("bp_pre_id", int'(out_id), 1);
        chk("bp_pre_gray", int'(out_gray), 7);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #3;
            chk("bp_gray", int'(out_gray), 7);
            chk("bp_id", int'(out_id), 1);
            chk("bp_ready", int'(req_ready), 0);
            chk("bp_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1 chk("bp_rel_ready", int'(req_ready), 4'b0100);
        @(posedge clk); #3;
        chk("bp_rel_id", int'(out_id), 2);
        chk("bp_rel_gray", int'(out_gray), 15);
        req_valid = 4'b1000;
        req_data[3*WIDTH +: WIDTH] = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #3;
            chk("exh_gray", int'(out_gray), exh_gray[i]);
            chk("exh_id", int'(out_id), 3);
            chk("exh_valid", int'(out_valid), 1);
            if (i < 15) req_data[3*WIDTH +: WIDTH] = WIDTH'(i + 1);
            else req_valid = '0;
        end
        @(posedge clk); #3;
        chk("exh_drain", int'(out_valid), 0);
        req_valid = 4'b0100;
        req_data[2*WIDTH +: WIDTH] = 4'd8;
        @(posedge clk); #3;
        chk("idle_gray", int'(out_gray), 12);
        chk("idle_id", int'(out_id), 2);
        req_valid = '0;
        @(posedge clk); #3;
        chk("idle_drain", int'(out_valid), 0);
        req_valid = 4'b1010;
        #1 chk("sparse_ready", int'(req_ready), 4'b1000);
        @(posedge clk); #3;
        chk("sparse_id", int'(out_id), 3);
        chk("sparse_gray", int'(out_gray), 8);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(out_valid), 0);
        chk("ar_gray", int'(out_gray), 0);
        chk("ar_id", int'(out_id), 0);
        chk("ar_ready", int'(req_ready), 0);
        #3 rst_n = 1'b1;
        #1 chk("ar_rel_ready", int'(req_ready), 4'b0010);
        @(posedge clk); #3;
        chk("ar_rel_id", int'(out_id), 1);
        chk("ar_rel_gray", int'(out_gray), 7);
`else
        repeat (10) begin
            @(posedge clk); #3;
            chk("p0_id", int'(out_id), 0);
            chk("p0_gray", int'(out_gray), 3);
        end
        req_valid = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            chk("p0_rr_id", int'(out_id), pr_ids[i]);
            chk("p0_rr_gray", int'(out_gray), pr_grays[i]);
        end
`endif
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            req_data  = (NREQ*WIDTH)'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
